icache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the instruction fetcher
//  (upstream requester) and the memory controller (line refill).
//  - Hit: returns the 32-bit word to the fetcher one cycle after the request.
//  - Miss: refills the whole line word-by-word from the memory controller,

---
 rtl/icache_pkg.sv | 17 +
 rtl/icache_data_ram.sv | 33 +++
 rtl/icache.sv | 169 ++++++++++++++++
 tb/tb_icache.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default geometry and FSM encodings.
package icache_pkg;

  // Default geometry (byte address width, log2 words per line, log2 line count).
  localparam int IC_ADDR_WIDTH  = 32;
  localparam int IC_BLOCK_WIDTH = 1;
  localparam int IC_CACHE_WIDTH = 8;

  // Byte-within-word offset bits; always ignored for word fetches.
  localparam int IC_BYTE_WIDTH  = 2;

  // Controller states.
  localparam logic [1:0] IC_IDLE = 2'd0;
  localparam logic [1:0] IC_FILL = 2'd1;
  localparam logic [1:0] IC_RESP = 2'd2;

endpackage

// File: rtl/icache_data_ram.sv
// Line data storage: one write port and one registered read port.
// The read register resets to zero so the fetch data output starts clean.
module icache_data_ram #(
  parameter int AW = 9
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [1<<AW];
  logic [31:0] rdata_q;

  // Write port.
  // NOTE: storage arrays carry no reset; the valid bits decide whether contents mean anything.
  always_ff @(posedge clk_in) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Registered read port; holds its value whenever no read is requested.
  always_ff @(posedge clk_in) begin
    if (rst_in)  rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetcher and the
// memory controller. Hits answer one cycle after the request; misses refill
// the whole line word by word, then answer. A ROB clear aborts everything.
module icache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = IC_ADDR_WIDTH,
  parameter int BLOCK_WIDTH = IC_BLOCK_WIDTH,
  parameter int CACHE_WIDTH = IC_CACHE_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  IF2IC_en,
  input  logic [ADDR_WIDTH-1:0] IF2IC_addr,
  output logic                  IC2IF_en,
  output logic [31:0]           IC2IF_data,
  output logic                  IC2MC_en,
  output logic [ADDR_WIDTH-1:0] IC2MC_addr,
  input  logic                  MC2IC_en,
  input  logic [31:0]           MC2IC_data,
  input  logic                  RoB2IC_clear
);

  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int BLOCK_NUM  = 1 << CACHE_WIDTH;
  localparam int OFF_W      = BLOCK_WIDTH + IC_BYTE_WIDTH;
  localparam int TAG_W      = ADDR_WIDTH - CACHE_WIDTH - OFF_W;
  localparam int RAM_AW     = CACHE_WIDTH + BLOCK_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [BLOCK_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
  logic                   resp_q, resp_d;
  logic                   mc_en_q, mc_en_d;
  logic [ADDR_WIDTH-1:0]  mc_addr_q, mc_addr_d;
  logic [BLOCK_NUM-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [BLOCK_NUM];
  logic                   tag_we;

  logic                   ram_we, ram_re;
  logic [RAM_AW-1:0]      ram_waddr, ram_raddr;

  // Address fields of the incoming request and of the latched miss.
  logic [BLOCK_WIDTH-1:0] if_word, req_word;
  logic [CACHE_WIDTH-1:0] if_index, req_index;
  logic [TAG_W-1:0]       if_tag, req_tag;
  logic                   hit;

  assign if_word   = IF2IC_addr[OFF_W-1:IC_BYTE_WIDTH];
  assign if_index  = IF2IC_addr[CACHE_WIDTH+OFF_W-1:OFF_W];
  assign if_tag    = IF2IC_addr[ADDR_WIDTH-1:CACHE_WIDTH+OFF_W];
  assign req_word  = req_addr_q[OFF_W-1:IC_BYTE_WIDTH];
  assign req_index = req_addr_q[CACHE_WIDTH+OFF_W-1:OFF_W];
  assign req_tag   = req_addr_q[ADDR_WIDTH-1:CACHE_WIDTH+OFF_W];
  assign hit       = valid_q[if_index] && (tag_q[if_index] == if_tag);

  // Byte-offset bits never select anything.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{IF2IC_addr[IC_BYTE_WIDTH-1:0], req_addr_q[IC_BYTE_WIDTH-1:0]};

  // Next-state logic: freeze when not ready, abort on clear, otherwise run the FSM.
  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    resp_d     = 1'b0;
    mc_en_d    = mc_en_q;
    mc_addr_d  = mc_addr_q;
    valid_d    = valid_q;
    tag_we     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = {req_index, cnt_q};
    ram_raddr  = {if_index, if_word};

    if (!rdy_in) begin
      resp_d = resp_q;
    end else if (RoB2IC_clear) begin
      state_d = IC_IDLE;
      cnt_d   = '0;
      mc_en_d = 1'b0;
    end else begin
      case (state_q)
        IC_IDLE: begin
          if (IF2IC_en) begin
            if (hit) begin
              resp_d = 1'b1;
              ram_re = 1'b1;
            end else begin
              req_addr_d        = IF2IC_addr;
              mc_en_d           = 1'b1;
              mc_addr_d         = {IF2IC_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
              valid_d[if_index] = 1'b0;
              state_d           = IC_FILL;
            end
          end
        end
        IC_FILL: begin
          if (MC2IC_en) begin
            ram_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == BLOCK_WIDTH'(BLOCK_SIZE - 1)) begin
              tag_we             = 1'b1;
              valid_d[req_index] = 1'b1;
              mc_en_d            = 1'b0;
              cnt_d              = '0;
              state_d            = IC_RESP;
            end
          end
        end
        IC_RESP: begin
          resp_d    = 1'b1;
          ram_re    = 1'b1;
          ram_raddr = {req_index, req_word};
          cnt_d     = '0;
          state_d   = IC_IDLE;
        end
        default: state_d = IC_IDLE;
      endcase
    end
  end

  // Control and valid-bit registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst_in) begin
      state_q    <= IC_IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      resp_q     <= 1'b0;
      mc_en_q    <= 1'b0;
      mc_addr_q  <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      resp_q     <= resp_d;
      mc_en_q    <= mc_en_d;
      mc_addr_q  <= mc_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag array, written once a line is completely filled.
  always_ff @(posedge clk_in) begin
    if (tag_we) tag_q[req_index] <= req_tag;
  end

  icache_data_ram #(
    .AW(RAM_AW)
  ) u_data_ram (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (MC2IC_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (IC2IF_data)
  );

  assign IC2IF_en   = resp_q;
  assign IC2MC_en   = mc_en_q;
  assign IC2MC_addr = mc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches,
// checked against a line-level model of a direct-mapped cache.
module tb_icache;

  localparam int AW = 32;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, IF2IC_en, MC2IC_en, RoB2IC_clear;
  logic [AW-1:0] IF2IC_addr;
  logic [31:0]   MC2IC_data;
  logic          IC2IF_en, IC2MC_en;
  logic [31:0]   IC2IF_data;
  logic [AW-1:0] IC2MC_addr;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: one valid bit and tag per line (8 index bits, 8-byte lines).
  bit          m_valid [256];
  logic [20:0] m_tag   [256];

  always #5 clk_in = ~clk_in;

  icache dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .IF2IC_en    (IF2IC_en),
    .IF2IC_addr  (IF2IC_addr),
    .IC2IF_en    (IC2IF_en),
    .IC2IF_data  (IC2IF_data),
    .IC2MC_en    (IC2MC_en),
    .IC2MC_addr  (IC2MC_addr),
    .MC2IC_en    (MC2IC_en),
    .MC2IC_data  (MC2IC_data),
    .RoB2IC_clear(RoB2IC_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Backing memory contents: the two specified words at 0x0/0x4, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 3) & 32'hFF);
  endfunction

  function automatic logic [20:0] tag_of(input logic [31:0] a);
    return a[31:11];
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic tick();
    @(negedge clk_in);
  endtask

  // One complete fetch; the model decides hit or miss and what every cycle must show.
  task automatic fetch(input logic [31:0] a, input int lat);
    bit          exp_hit = model_hit(a);
    logic [31:0] base    = {a[31:3], 3'b000};
    IF2IC_en   = 1'b1;
    IF2IC_addr = a;
    tick();
    IF2IC_en   = 1'b0;
    if (exp_hit) begin
      check("hit_en",    {31'b0, IC2IF_en}, 32'd1);
      check("hit_data",  IC2IF_data, mem_word(a));
      check("hit_no_mc", {31'b0, IC2MC_en}, 32'd0);
      tick();
      check("hit_pulse", {31'b0, IC2IF_en}, 32'd0);
    end else begin
      check("miss_mc_en",   {31'b0, IC2MC_en}, 32'd1);
      check("miss_mc_addr", IC2MC_addr, base);
      check("miss_no_resp", {31'b0, IC2IF_en}, 32'd0);
      m_valid[idx_of(a)] = 1'b0;
      for (int i = 0; i < lat; i++) begin
        tick();
        check("wait_mc_en", {31'b0, IC2MC_en}, 32'd1);
      end
      for (int w = 0; w < 2; w++) begin
        MC2IC_en   = 1'b1;
        MC2IC_data = mem_word(base + 32'(4 * w));
        tick();
      end
      MC2IC_en = 1'b0;
      check("fill_mc_drop", {31'b0, IC2MC_en}, 32'd0);
      check("fill_no_resp", {31'b0, IC2IF_en}, 32'd0);
      tick();
      check("miss_resp_en",   {31'b0, IC2IF_en}, 32'd1);
      check("miss_resp_data", IC2IF_data, mem_word(a));
      tick();
      check("miss_resp_once", {31'b0, IC2IF_en}, 32'd0);
      m_valid[idx_of(a)] = 1'b1;
      m_tag[idx_of(a)]   = tag_of(a);
    end
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; IF2IC_en = 1'b0; IF2IC_addr = '0;
    MC2IC_en = 1'b0; MC2IC_data = '0; RoB2IC_clear = 1'b0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    repeat (2) tick();
    rst_in = 1'b0;
    tick();

    // Reset state.
    check("rst_if_en",   {31'b0, IC2IF_en}, 32'd0);
    check("rst_if_data", IC2IF_data, 32'd0);
    check("rst_mc_en",   {31'b0, IC2MC_en}, 32'd0);
    check("rst_mc_addr", IC2MC_addr, 32'd0);

    // Cold miss, hit after fill, conflict eviction.
    fetch(32'h0000_0000, 3);
    fetch(32'h0000_0004, 0);
    fetch(32'h0000_0800, 2);
    fetch(32'h0000_0000, 1);

    // Clear with a simultaneous request: the request is dropped.
    IF2IC_en = 1'b1; IF2IC_addr = 32'h0000_0040; RoB2IC_clear = 1'b1;
    tick();
    IF2IC_en = 1'b0; RoB2IC_clear = 1'b0;
    check("clr_req_mc", {31'b0, IC2MC_en}, 32'd0);
    check("clr_req_if", {31'b0, IC2IF_en}, 32'd0);

    // Clear mid-fill: abort after the first word, stale word ignored, refetch.
    IF2IC_en = 1'b1; IF2IC_addr = 32'h0000_1000;
    tick();
    IF2IC_en = 1'b0;
    check("cmf_mc_en",   {31'b0, IC2MC_en}, 32'd1);
    check("cmf_mc_addr", IC2MC_addr, 32'h0000_1000);
    m_valid[idx_of(32'h1000)] = 1'b0;
    MC2IC_en = 1'b1; MC2IC_data = mem_word(32'h1000);
    tick();
    MC2IC_en = 1'b0; RoB2IC_clear = 1'b1;
    tick();
    RoB2IC_clear = 1'b0;
    check("cmf_mc_drop", {31'b0, IC2MC_en}, 32'd0);
    check("cmf_no_resp", {31'b0, IC2IF_en}, 32'd0);
    MC2IC_en = 1'b1; MC2IC_data = 32'hDEAD_BEEF;
    tick();
    MC2IC_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("cmf_quiet_if", {31'b0, IC2IF_en}, 32'd0);
      check("cmf_quiet_mc", {31'b0, IC2MC_en}, 32'd0);
      tick();
    end
    fetch(32'h0000_1004, 2);
    fetch(32'h0000_1000, 0);

    // rdy_in low for 5 cycles in the middle of a fill.
    IF2IC_en = 1'b1; IF2IC_addr = 32'h0000_0014;
    tick();
    IF2IC_en = 1'b0;
    check("rdy_mc_en", {31'b0, IC2MC_en}, 32'd1);
    m_valid[idx_of(32'h14)] = 1'b0;
    MC2IC_en = 1'b1; MC2IC_data = mem_word(32'h10);
    tick();
    MC2IC_en = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rdy_hold_mc",   {31'b0, IC2MC_en}, 32'd1);
      check("rdy_hold_addr", IC2MC_addr, 32'h0000_0010);
      check("rdy_hold_if",   {31'b0, IC2IF_en}, 32'd0);
    end
    rdy_in = 1'b1;
    MC2IC_en = 1'b1; MC2IC_data = mem_word(32'h14);
    tick();
    MC2IC_en = 1'b0;
    check("rdy_mc_drop", {31'b0, IC2MC_en}, 32'd0);
    tick();
    check("rdy_resp_en",   {31'b0, IC2IF_en}, 32'd1);
    check("rdy_resp_data", IC2IF_data, mem_word(32'h14));
    tick();
    m_valid[idx_of(32'h14)] = 1'b1;
    m_tag[idx_of(32'h14)]   = tag_of(32'h14);
    fetch(32'h0000_0010, 0);

    // Reset mid-fill: outputs return to zero and earlier lines are forgotten.
    fetch(32'h0000_0020, 1);
    fetch(32'h0000_0020, 0);
    IF2IC_en = 1'b1; IF2IC_addr = 32'h0000_0040;
    tick();
    IF2IC_en = 1'b0;
    MC2IC_en = 1'b1; MC2IC_data = mem_word(32'h40);
    tick();
    MC2IC_en = 1'b0; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("rmf_if_en",   {31'b0, IC2IF_en}, 32'd0);
    check("rmf_if_data", IC2IF_data, 32'd0);
    check("rmf_mc_en",   {31'b0, IC2MC_en}, 32'd0);
    check("rmf_mc_addr", IC2MC_addr, 32'd0);
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    fetch(32'h0000_0020, 0);

    // Random fetches over a small pool of tags/indices to mix hits and conflicts.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 11) | ($urandom_range(0, 7) << 3) | ($urandom_range(0, 1) << 2);
      fetch(a, int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
